// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: pulses o_match when the last LEN accepted bits equal
// the run-time loadable pattern, with overlap mode and a saturating match counter.
module seq_pattern_detector #(
   parameter int             LEN     = 5,
   parameter logic [LEN-1:0] PATTERN = 5'b10010,
   parameter logic           OVERLAP = 1'b1,
   parameter int             CNT_W   = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   input  logic             i_in_bit,
   input  logic             i_cfg_load,
   input  logic [LEN-1:0]   i_cfg_pattern,
   input  logic             i_cfg_overlap,
   input  logic             i_clr_cnt,
   output logic             o_match,
   output logic [CNT_W-1:0] o_match_cnt,
   output logic             o_cnt_sat
);

   localparam int               FW       = $clog2(LEN);
   localparam logic [FW-1:0]    FILL_MAX = FW'(LEN - 1);
   localparam logic [FW-1:0]    FILL_ONE = FW'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [LEN-1:0]   r_pat;
   logic             r_ovl;
   logic [LEN-1:0]   r_hist;
   logic [FW-1:0]    r_fill;
   logic             r_match;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sat;

   logic [LEN-1:0]   w_shift;
   logic             w_accept;
   logic             w_hit;
   logic [FW-1:0]    w_fill_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;

   assign w_shift  = {r_hist[LEN-2:0], i_in_bit};
   assign w_accept = i_in_valid & ~i_cfg_load;
   assign w_hit    = w_accept & (r_fill == FILL_MAX) & (w_shift == r_pat);

   // Next fill level and next counter value
   always_comb begin
      w_fill_nxt = r_fill;
      w_cnt_nxt  = r_cnt;

      if (i_cfg_load) begin
         w_fill_nxt = '0;
      end else if (w_accept) begin
         // a non-overlapping hit forces LEN fresh bits before the next match
         if (w_hit && !r_ovl) begin
            w_fill_nxt = '0;
         end else if (r_fill == FILL_MAX) begin
            w_fill_nxt = FILL_MAX;
         end else begin
            w_fill_nxt = r_fill + FILL_ONE;
         end
      end else begin
         w_fill_nxt = r_fill;
      end

      if (w_hit) begin
         if (i_clr_cnt) begin
            w_cnt_nxt = CNT_ONE;
         end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
         end else begin
            w_cnt_nxt = r_cnt;
         end
      end else if (i_clr_cnt) begin
         w_cnt_nxt = '0;
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Pattern/mode, history, phase, counter and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pat   <= PATTERN;
         r_ovl   <= OVERLAP;
         r_hist  <= '0;
         r_fill  <= '0;
         r_match <= 1'b0;
         r_cnt   <= '0;
         r_sat   <= 1'b0;
      end else begin
         if (i_cfg_load) begin
            r_pat  <= i_cfg_pattern;
            r_ovl  <= i_cfg_overlap;
            r_hist <= '0;
         end else if (w_accept) begin
            r_hist <= w_shift;
         end else begin
            r_hist <= r_hist;
         end
         r_fill  <= w_fill_nxt;
         r_match <= w_hit;
         r_cnt   <= w_cnt_nxt;
         r_sat   <= (w_cnt_nxt == CNT_MAX);
      end
   end

   assign o_match     = r_match;
   assign o_match_cnt = r_cnt;
   assign o_cnt_sat   = r_sat;

endmodule
